uart_tx_frame_sequencer: RTL and testbench

//  Parametrised frame-level UART transmit sequencer. Loads a multi-byte message (AES block) into the PISO,

---
 rtl/uart_tx_frame_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_tx_frame_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_sequencer.sv
// uart_tx_frame_sequencer
//
// Frame-level UART transmit sequencer. It loads one message into the PISO.
// It then hands the message one byte at a time to the UART data register (UDR)
// and the UART transmitter. An optional idle gap separates consecutive bytes, and
// a timeout bounds the wait for each byte's tx_done. The block also keeps the byte
// index and a sticky timeout flag, and it drives the status outputs.
//
// Optional feature: define SEQ_CRC_APPEND_EN to append CRC_BYTES CRC bytes after
// the payload. For those bytes the UDR reads the CRC register (crc_sel_o) and the
// PISO is not advanced. When the macro is undefined, crc_sel_o is tied low and
// CRC_BYTES has no effect.
//
// Parameters
//   DATA_BYTES      payload bytes per frame (>= 1)
//   CRC_BYTES       CRC bytes appended per frame (only with SEQ_CRC_APPEND_EN)
//   GAP_CYCLES      idle clocks between tx_done and the next UDR load (0 = none)
//   TIMEOUT_CYCLES  max clocks spent waiting for tx_done before the frame is dropped
//   CNT_W           byte_idx_o width, must hold TOTAL-1
//
// Ports
//   clk            clock
//   reset          synchronous, active-high reset
//   start_i        frame request, honoured only when idle
//   abort_i        cancel the current frame (highest priority)
//   tx_done_i      UART byte complete, honoured only while waiting for it
//   piso_reset_o   PISO clear (high while idle)
//   piso_load_o    PISO parallel load
//   piso_shift_o   registered pulse: advance PISO to the next byte
//   crc_clear_o    clear the CRC accumulator at frame start
//   crc_en_o       CRC consumes the current PISO byte
//   crc_sel_o      UDR source: 1 = CRC register, 0 = PISO
//   udr_load_o     UDR captures the selected byte
//   tx_en_o        UART Tx enable
//   tx_start_o     UART Tx start pulse
//   busy_o         high whenever not idle
//   frame_done_o   one-cycle pulse when the last byte has completed
//   timeout_err_o  sticky timeout flag, cleared when a new frame is accepted
//   byte_idx_o     index of the byte in flight

module uart_tx_frame_sequencer #(
  parameter int unsigned DATA_BYTES     = 16,
  parameter int unsigned CRC_BYTES      = 2,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             tx_done_i,
  output logic             piso_reset_o,
  output logic             piso_load_o,
  output logic             piso_shift_o,
  output logic             crc_clear_o,
  output logic             crc_en_o,
  output logic             crc_sel_o,
  output logic             udr_load_o,
  output logic             tx_en_o,
  output logic             tx_start_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             timeout_err_o,
  output logic [CNT_W-1:0] byte_idx_o
);

`ifdef SEQ_CRC_APPEND_EN
  localparam int unsigned Total = DATA_BYTES + CRC_BYTES;
`else
  localparam int unsigned Total = DATA_BYTES;
`endif

  // A single counter serves the timeout wait and the inter-byte gap. The two are
  // never active at the same time.
  localparam int unsigned CntMax = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int unsigned TmrW   = $clog2(CntMax + 1);

  localparam logic [TmrW-1:0] TimeoutLast = TmrW'(TIMEOUT_CYCLES - 1);
  localparam logic [TmrW-1:0] GapLast     = TmrW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFetch,
    StStart,
    StWaitDone,
    StGap,
    StFinish
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] byte_idx_q, byte_idx_d;
  logic [TmrW-1:0]  cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             piso_shift_q, piso_shift_d;

  logic is_last;
  logic in_data;
  logic shift_ok;

  // Compare in 32 bits so that a byte index equal to 2**CNT_W cannot alias to 0.
  assign is_last = (32'(byte_idx_q) == Total - 1);
  assign in_data = (32'(byte_idx_q) < DATA_BYTES);

`ifdef SEQ_CRC_APPEND_EN
  // CRC bytes come from the CRC register, so the PISO must not advance past them.
  assign shift_ok = in_data;
`else
  assign shift_ok = 1'b1;
`endif

  //--------------------------------------------------------------------------
  // State register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      byte_idx_q    <= '0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
      piso_shift_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
      piso_shift_q  <= piso_shift_d;
    end
  end

  //--------------------------------------------------------------------------
  // Next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    piso_shift_d  = 1'b0;

    if (abort_i && (state_q != StIdle)) begin
      // Abort overrides start, tx_done and timeout. The timeout flag and
      // byte_idx keep their values.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d       = StLoad;
            timeout_err_d = 1'b0;
          end
        end

        StLoad: begin
          byte_idx_d = '0;
          state_d    = StFetch;
        end

        StFetch: begin
          state_d = StStart;
        end

        StStart: begin
          cnt_d   = '0;
          state_d = StWaitDone;
        end

        StWaitDone: begin
          // If tx_done arrives in the same cycle as the timeout, tx_done wins.
          if (tx_done_i) begin
            cnt_d = '0;
            if (is_last) begin
              state_d = StFinish;
            end else begin
              byte_idx_d   = byte_idx_q + 1'b1;
              piso_shift_d = shift_ok;
              state_d      = (GAP_CYCLES == 0) ? StFetch : StGap;
            end
          end else if (cnt_q == TimeoutLast) begin
            timeout_err_d = 1'b1;
            state_d       = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        StGap: begin
          if (cnt_q == GapLast) begin
            cnt_d   = '0;
            state_d = StFetch;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        StFinish: begin
          state_d = StIdle;
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Moore outputs, decoded from the state register
  //--------------------------------------------------------------------------
  always_comb begin
    piso_reset_o = (state_q == StIdle);
    piso_load_o  = (state_q == StLoad);
    crc_clear_o  = (state_q == StLoad);
    udr_load_o   = (state_q == StFetch);
    crc_en_o     = (state_q == StFetch) && in_data;
`ifdef SEQ_CRC_APPEND_EN
    crc_sel_o    = (state_q == StFetch) && !in_data;
`else
    crc_sel_o    = 1'b0;
`endif
    tx_en_o      = (state_q == StStart) || (state_q == StWaitDone);
    tx_start_o   = (state_q == StStart);
    busy_o       = (state_q != StIdle);
    frame_done_o = (state_q == StFinish);
  end

  assign piso_shift_o  = piso_shift_q;
  assign timeout_err_o = timeout_err_q;
  assign byte_idx_o    = byte_idx_q;

endmodule

// File: tb/tb_uart_tx_frame_sequencer.sv
// Testbench for uart_tx_frame_sequencer.
//
// The reference model predicts each frame as a schedule of per-cycle output
// vectors: load, fetch, start, an open-ended wait for tx_done, then gap cycles and
// the next fetch/start, or finish. A compare process checks the DUT against this
// schedule on every cycle. The directed scenarios add hand-computed latency and
// count checks. A randomized phase follows them.

module tb_uart_tx_frame_sequencer;

  localparam int unsigned DataBytes     = 16;
  localparam int unsigned CrcBytes      = 2;
  localparam int unsigned GapCycles     = 2;
  localparam int unsigned TimeoutCycles = 50;
  localparam int unsigned CntW          = 5;

`ifdef SEQ_CRC_APPEND_EN
  localparam int Total = 18;
  localparam int T1Len = 252;  // 3 + 17*14 + 10 + 1
`else
  localparam int Total = 16;
  localparam int T1Len = 224;  // 3 + 15*14 + 10 + 1
`endif

  // Output vector bit masks
  localparam logic [10:0] MPr = 11'h400;  // piso_reset
  localparam logic [10:0] MLd = 11'h200;  // piso_load
  localparam logic [10:0] MSh = 11'h100;  // piso_shift
  localparam logic [10:0] MCc = 11'h080;  // crc_clear
  localparam logic [10:0] MCe = 11'h040;  // crc_en
  localparam logic [10:0] MCs = 11'h020;  // crc_sel
  localparam logic [10:0] MUd = 11'h010;  // udr_load
  localparam logic [10:0] MTe = 11'h008;  // tx_en
  localparam logic [10:0] MTs = 11'h004;  // tx_start
  localparam logic [10:0] MBy = 11'h002;  // busy
  localparam logic [10:0] MFd = 11'h001;  // frame_done

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_i = 1'b0;
  logic abort_i = 1'b0;
  logic tx_done_i = 1'b0;

  logic            piso_reset_o, piso_load_o, piso_shift_o, crc_clear_o, crc_en_o, crc_sel_o;
  logic            udr_load_o, tx_en_o, tx_start_o, busy_o, frame_done_o, timeout_err_o;
  logic [CntW-1:0] byte_idx_o;

  uart_tx_frame_sequencer #(
    .DATA_BYTES    (DataBytes),
    .CRC_BYTES     (CrcBytes),
    .GAP_CYCLES    (GapCycles),
    .TIMEOUT_CYCLES(TimeoutCycles),
    .CNT_W         (CntW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .tx_done_i    (tx_done_i),
    .piso_reset_o (piso_reset_o),
    .piso_load_o  (piso_load_o),
    .piso_shift_o (piso_shift_o),
    .crc_clear_o  (crc_clear_o),
    .crc_en_o     (crc_en_o),
    .crc_sel_o    (crc_sel_o),
    .udr_load_o   (udr_load_o),
    .tx_en_o      (tx_en_o),
    .tx_start_o   (tx_start_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .timeout_err_o(timeout_err_o),
    .byte_idx_o   (byte_idx_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  //--------------------------------------------------------------------------
  // Reference model: schedule of expected output vectors
  //--------------------------------------------------------------------------
  typedef struct {
    logic [10:0] f;
    int          idx;
  } exp_t;

  exp_t sched[$];
  exp_t cur;
  bit   waiting = 1'b0;
  int   wn = 0;
  bit   m_terr = 1'b0;
  bit   mdl_on = 1'b0;

  function automatic exp_t mk(input logic [10:0] f, input int idx);
    exp_t e;
    e.f   = f;
    e.idx = idx;
    return e;
  endfunction

  function automatic exp_t fetch_vec(input int idx, input bit shift);
    logic [10:0] f;
    f = MBy | MUd;
    if (idx < int'(DataBytes)) f = f | MCe;
`ifdef SEQ_CRC_APPEND_EN
    else f = f | MCs;
`endif
    if (shift) f = f | MSh;
    return mk(f, idx);
  endfunction

  always @(posedge clk) begin : model
    bit shift;
    int n;
    if (reset) begin
      sched.delete();
      waiting = 1'b0;
      m_terr  = 1'b0;
      cur     = mk(MPr, 0);
      mdl_on  = 1'b1;
    end else if (mdl_on) begin
      if (((cur.f & MBy) != 0) && abort_i) begin
        sched.delete();
        waiting = 1'b0;
        cur     = mk(MPr, cur.idx);
      end else if ((cur.f & MBy) == 0) begin
        if (start_i && !abort_i) begin
          m_terr = 1'b0;
          sched.push_back(mk(MBy | MLd | MCc, cur.idx));
          sched.push_back(fetch_vec(0, 1'b0));
          sched.push_back(mk(MBy | MTe | MTs, 0));
          cur = sched.pop_front();
        end
      end else if (waiting) begin
        if (tx_done_i) begin
          waiting = 1'b0;
          if (cur.idx == Total - 1) begin
            sched.push_back(mk(MBy | MFd, cur.idx));
          end else begin
`ifdef SEQ_CRC_APPEND_EN
            shift = (cur.idx < int'(DataBytes));
`else
            shift = 1'b1;
`endif
            n = cur.idx + 1;
            for (int g = 0; g < int'(GapCycles); g++)
              sched.push_back(mk((g == 0 && shift) ? (MBy | MSh) : MBy, n));
            sched.push_back(fetch_vec(n, shift && (GapCycles == 0)));
            sched.push_back(mk(MBy | MTe | MTs, n));
          end
          cur = sched.pop_front();
        end else if (wn == int'(TimeoutCycles)) begin
          waiting = 1'b0;
          m_terr  = 1'b1;
          cur     = mk(MPr, cur.idx);
        end else begin
          wn++;
        end
      end else if (sched.size() > 0) begin
        cur = sched.pop_front();
      end else if ((cur.f & MTs) != 0) begin
        waiting = 1'b1;
        wn      = 1;
        cur     = mk(MBy | MTe, cur.idx);
      end else begin
        cur = mk(MPr, cur.idx);
      end
    end
  end

  //--------------------------------------------------------------------------
  // Per-cycle compare against the model
  //--------------------------------------------------------------------------
  int cyc = 0;

  always @(negedge clk) begin : compare
    logic [10:0] act;
    act = {piso_reset_o, piso_load_o, piso_shift_o, crc_clear_o, crc_en_o, crc_sel_o,
           udr_load_o, tx_en_o, tx_start_o, busy_o, frame_done_o};
    if (mdl_on) begin
      n_chk++;
      if (act === cur.f && byte_idx_o === CntW'(cur.idx) && timeout_err_o === m_terr)
        n_pass++;
      else
        $display("FAIL cycle_model cyc %0d: got outputs %b idx %0d terr %b, required %b idx %0d terr %b",
                 cyc, act, byte_idx_o, timeout_err_o, cur.f, cur.idx, m_terr);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  //--------------------------------------------------------------------------
  // Stimulus: cycle stepping, tx_done responder, event counters
  //--------------------------------------------------------------------------
  int n_txs = 0;
  int n_fd = 0;
  int first_txs = -1;
  int last_fd = -1;
  int cd = 0;
  int delay = 10;
  bit withhold = 1'b0;
  bit rnd = 1'b0;
  bit noise = 1'b0;

  task automatic clear_counts();
    n_txs     = 0;
    n_fd      = 0;
    first_txs = -1;
    last_fd   = -1;
  endtask

  task automatic tick();
    bit wh;
    @(posedge clk);
    #2;
    cyc++;
    if (tx_start_o) begin
      n_txs++;
      if (first_txs < 0) first_txs = cyc;
    end
    if (frame_done_o) begin
      n_fd++;
      last_fd = cyc;
    end
    if (cd > 0) begin
      cd--;
      tx_done_i = (cd == 0);
    end else begin
      tx_done_i = noise && ($urandom_range(0, 29) == 0);
    end
    if (tx_start_o) begin
      wh = rnd ? ($urandom_range(0, 7) == 0) : withhold;
      if (!wh) cd = rnd ? int'($urandom_range(1, 12)) : delay;
    end
  endtask

  task automatic run_to_done(input int budget);
    for (int i = 0; i < budget && n_fd == 0; i++) tick();
  endtask

  initial begin
    int a;
    int hold;

    // Reset
    repeat (3) tick();
    reset = 1'b0;
    check("rst_piso_reset", int'(piso_reset_o), 1);
    check("rst_busy", int'(busy_o), 0);
    check("rst_byte_idx", int'(byte_idx_o), 0);
    check("rst_timeout_err", int'(timeout_err_o), 0);
    tick();

    // 1: single start pulse, tx_done 10 cycles after each tx_start
    delay = 10;
    clear_counts();
    start_i = 1'b1;
    a = cyc;
    tick();
    start_i = 1'b0;
    run_to_done(400);
    check("t1_first_tx_start_latency", first_txs - a, 3);
    check("t1_frame_done_latency", last_fd - a, T1Len);
    check("t1_tx_start_count", n_txs, Total);
    check("t1_frame_done_count", n_fd, 1);
    check("t1_timeout_err", int'(timeout_err_o), 0);
    repeat (2) tick();

    // 2: start held for a whole frame, then re-accepted only from idle
    delay = 3;
    clear_counts();
    hold = 7 * Total + 1;
    start_i = 1'b1;
    a = cyc;
    for (int i = 0; i < hold; i++) tick();
    check("t2_idle_after_frame", int'(busy_o), 0);
    check("t2_tx_start_count", n_txs, Total);
    check("t2_frame_done_count", n_fd, 1);
    tick();
    start_i = 1'b0;
    check("t2_restart_load", int'(piso_load_o), 1);
    clear_counts();
    run_to_done(300);
    check("t2_second_frame_done", n_fd, 1);
    repeat (2) tick();

    // 3: tx_done withheld, timeout after 50 wait cycles
    withhold = 1'b1;
    clear_counts();
    start_i = 1'b1;
    a = cyc;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 200 && !timeout_err_o; i++) tick();
    check("t3_timeout_latency", cyc - a, 54);
    check("t3_idle_after_timeout", int'(busy_o), 0);
    check("t3_no_frame_done", n_fd, 0);
    check("t3_tx_start_count", n_txs, 1);
    withhold = 1'b0;
    delay = 4;
    tick();
    check("t3_err_sticky", int'(timeout_err_o), 1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("t3_err_cleared_on_start", int'(timeout_err_o), 0);
    clear_counts();
    run_to_done(300);
    check("t3_recovery_frame", n_fd, 1);
    repeat (2) tick();

    // 4: abort after byte 5's tx_start
    delay = 10;
    clear_counts();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 300 && n_txs < 6; i++) tick();
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("t4_busy_after_abort", int'(busy_o), 0);
    check("t4_piso_reset_after_abort", int'(piso_reset_o), 1);
    repeat (60) tick();
    check("t4_tx_start_count", n_txs, 6);
    check("t4_no_frame_done", n_fd, 0);

    // 5: reset during the gap after byte 3
    delay = 5;
    clear_counts();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 300 && !(piso_shift_o && byte_idx_o == 4); i++) tick();
    check("t5_gap_found", int'(piso_shift_o && byte_idx_o == 4), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_reset_outputs",
          int'({piso_reset_o, piso_load_o, piso_shift_o, crc_clear_o, crc_en_o, crc_sel_o,
                udr_load_o, tx_en_o, tx_start_o, busy_o, frame_done_o}), int'(MPr));
    check("t5_reset_byte_idx", int'(byte_idx_o), 0);
    tick();
    clear_counts();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    run_to_done(300);
    check("t5_clean_frame_done", n_fd, 1);
    check("t5_clean_tx_start_count", n_txs, Total);
    repeat (2) tick();

    // Randomized traffic, checked cycle by cycle against the model
    rnd = 1'b1;
    noise = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset   = ($urandom_range(0, 399) == 0);
      start_i = ($urandom_range(0, 11) == 0);
      abort_i = ($urandom_range(0, 149) == 0);
    end
    rnd = 1'b0;
    noise = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
